// File: rtl/hvgen_pkg.sv
// Shared timing constants, frame-latched configuration types and the
// single-step modular wrap helper used by the hvgen raster generator.
package hvgen_pkg;

    localparam int MW = 16;

    localparam int S1_CW       = 9;
    localparam int S1_RGBW     = 12;
    localparam int S1_HTOTAL   = 320;
    localparam int S1_VTOTAL   = 260;
    localparam int S1_HPOS_OFS = 16;
    localparam int S1_HA0_B    = 29;
    localparam int S1_HA0_E    = 285;
    localparam int S1_HA1_B    = 37;
    localparam int S1_HA1_E    = 277;
    localparam int S1_VACT     = 224;
    localparam int S1_HS_BASE  = 296;
    localparam int S1_HS_LEN   = 32;
    localparam int S1_VS_BASE  = 234;
    localparam int S1_VS_LEN   = 4;

    // Wider-line board: 256-pixel mode-0 window inside a 384-clock line
    localparam int W256_HTOTAL   = 384;
    localparam int W256_HPOS_OFS = 48;
    localparam int W256_HA0_B    = 64;
    localparam int W256_HA0_E    = 320;
    localparam int W256_HA1_B    = 72;
    localparam int W256_HA1_E    = 312;
    localparam int W256_HS_BASE  = 336;
    localparam int W256_HS_LEN   = 32;

    typedef enum logic {
        MODE_W0 = 1'b0,
        MODE_W1 = 1'b1
    } hmode_e;

    typedef struct packed {
        hmode_e     mode;
        logic [3:0] hoffs;
        logic [3:0] voffs;
    } frame_cfg_t;

    // Operands stay within one period of total, so one correction step suffices
    function automatic logic [MW-1:0] mod_wrap(input logic signed [MW-1:0] val,
                                               input logic [MW-1:0]        total);
        logic signed [MW-1:0] tot_s;
        logic signed [MW-1:0] res_s;
        tot_s = $signed(total);
        if (val < 16'sd0) begin
            res_s = val + tot_s;
        end else if (val >= tot_s) begin
            res_s = val - tot_s;
        end else begin
            res_s = val;
        end
        return $unsigned(res_s);
    endfunction

endpackage

// File: rtl/hvgen_param_chk.sv
// Elaboration-time sanity checks on the timing parameter set.
module hvgen_param_chk
    import hvgen_pkg::*;
#(
    parameter int CW     = 9,
    parameter int HTOTAL = 320,
    parameter int VTOTAL = 260,
    parameter int HA0_B  = 29,
    parameter int HA0_E  = 285,
    parameter int HA1_B  = 37,
    parameter int HA1_E  = 277,
    parameter int HS_LEN = 32,
    parameter int VS_LEN = 4
)();

    if (CW + 1 > MW) begin : g_cw_chk
        $error("hvgen_param: CW too wide for mod_wrap intermediates");
    end
    if (HTOTAL > (1 << CW) || VTOTAL > (1 << CW)) begin : g_total_chk
        $error("hvgen_param: HTOTAL/VTOTAL exceed counter range");
    end
    if (HS_LEN >= HTOTAL || VS_LEN >= VTOTAL) begin : g_len_chk
        $error("hvgen_param: sync length must be shorter than the period");
    end
    if (HA0_B >= HA0_E || HA0_E > HTOTAL) begin : g_win0_chk
        $error("hvgen_param: mode-0 window must satisfy B < E <= HTOTAL");
    end
    if (HA1_B >= HA1_E || HA1_E > HTOTAL) begin : g_win1_chk
        $error("hvgen_param: mode-1 window must satisfy B < E <= HTOTAL");
    end

endmodule

// File: rtl/hvgen_param_sync_window.sv
// Active-low sync flag: low while cnt lies in [base, base+LEN) modulo TOTAL,
// so the window may straddle the counter wrap.
module sync_window
    import hvgen_pkg::*;
#(
    parameter int CW    = 9,
    parameter int TOTAL = 320,
    parameter int LEN   = 32
)(
    input  logic [CW-1:0] cnt,
    input  logic [CW-1:0] base,
    output logic          sync_n
);

    logic signed [CW:0] diff_s;
    logic [MW-1:0]      dist_s;

    // Distance of the counter past the window start, folded into [0, TOTAL)
    always_comb begin
        diff_s = $signed({1'b0, cnt}) - $signed({1'b0, base});
        dist_s = mod_wrap(MW'(diff_s), MW'(TOTAL));
        if (dist_s < MW'(LEN)) begin
            sync_n = 1'b0;
        end else begin
            sync_n = 1'b1;
        end
    end

endmodule

// File: rtl/hvgen_param.sv
// Parametrised raster timing generator: counters, blanking, syncs, blanked RGB
// and frame/vblank strobes, with mode and sync offsets latched once per frame.
module hvgen_param
    import hvgen_pkg::*;
#(
    parameter int CW       = S1_CW,
    parameter int RGBW     = S1_RGBW,
    parameter int HTOTAL   = S1_HTOTAL,
    parameter int VTOTAL   = S1_VTOTAL,
    parameter int HPOS_OFS = S1_HPOS_OFS,
    parameter int HA0_B    = S1_HA0_B,
    parameter int HA0_E    = S1_HA0_E,
    parameter int HA1_B    = S1_HA1_B,
    parameter int HA1_E    = S1_HA1_E,
    parameter int VACT     = S1_VACT,
    parameter int HS_BASE  = S1_HS_BASE,
    parameter int HS_LEN   = S1_HS_LEN,
    parameter int VS_BASE  = S1_VS_BASE,
    parameter int VS_LEN   = S1_VS_LEN
)(
    input  logic            CLK,
    input  logic            RESET,
    input  logic            PCLK_EN,
    input  logic            MODE,
    input  logic [3:0]      HOFFS,
    input  logic [3:0]      VOFFS,
    input  logic [RGBW-1:0] iRGB,
    output logic [CW-1:0]   HPOS,
    output logic [CW-1:0]   VPOS,
    output logic [RGBW-1:0] oRGB,
    output logic            HBLK,
    output logic            VBLK,
    output logic            HSYN,
    output logic            VSYN,
    output logic            FRAME_STB,
    output logic            VBL_STB
);

    logic [CW-1:0]      hcnt_r, vcnt_r;
    frame_cfg_t         cfg_r;
    logic [RGBW-1:0]    rgb_r;
    logic               hblk_r, vblk_r, hsyn_r, vsyn_r, frame_stb_r, vbl_stb_r;
    logic [CW:0]        win_b_s, win_e_s;
    logic signed [CW:0] hs_sum_s, vs_sum_s;
    logic [CW-1:0]      hs_b_s, vs_b_s;
    logic               hblk_s, vblk_s, hsyn_s, vsyn_s, line_end_s, frame_end_s;
    logic [RGBW-1:0]    rgb_s;

    hvgen_param_chk #(
        .CW(CW), .HTOTAL(HTOTAL), .VTOTAL(VTOTAL), .HA0_B(HA0_B), .HA0_E(HA0_E),
        .HA1_B(HA1_B), .HA1_E(HA1_E), .HS_LEN(HS_LEN), .VS_LEN(VS_LEN)
    ) u_chk ();

    // Window select, sync bases and the values registered on the next enable
    always_comb begin
        if (cfg_r.mode == MODE_W1) begin
            win_b_s = (CW+1)'(HA1_B);
            win_e_s = (CW+1)'(HA1_E);
        end else begin
            win_b_s = (CW+1)'(HA0_B);
            win_e_s = (CW+1)'(HA0_E);
        end
        hblk_s      = !(({1'b0, hcnt_r} >= win_b_s) && ({1'b0, hcnt_r} < win_e_s));
        vblk_s      = ({1'b0, vcnt_r} >= (CW+1)'(VACT));
        rgb_s       = (hblk_s || vblk_s) ? {RGBW{1'b0}} : iRGB;
        hs_sum_s    = $signed((CW+1)'(HS_BASE)) + $signed({{(CW-3){cfg_r.hoffs[3]}}, cfg_r.hoffs});
        vs_sum_s    = $signed((CW+1)'(VS_BASE)) + $signed({{(CW-3){cfg_r.voffs[3]}}, cfg_r.voffs});
        hs_b_s      = CW'(mod_wrap(MW'(hs_sum_s), MW'(HTOTAL)));
        vs_b_s      = CW'(mod_wrap(MW'(vs_sum_s), MW'(VTOTAL)));
        line_end_s  = (hcnt_r == CW'(HTOTAL - 1));
        frame_end_s = line_end_s && (vcnt_r == CW'(VTOTAL - 1));
    end

    sync_window #(.CW(CW), .TOTAL(HTOTAL), .LEN(HS_LEN)) u_hsync (
        .cnt(hcnt_r), .base(hs_b_s), .sync_n(hsyn_s)
    );

    sync_window #(.CW(CW), .TOTAL(VTOTAL), .LEN(VS_LEN)) u_vsync (
        .cnt(vcnt_r), .base(vs_b_s), .sync_n(vsyn_s)
    );

    // Raster counters, frame-boundary config latch and registered video outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hcnt_r      <= {CW{1'b0}};
            vcnt_r      <= {CW{1'b0}};
            cfg_r       <= '{mode: MODE_W0, hoffs: 4'd0, voffs: 4'd0};
            rgb_r       <= {RGBW{1'b0}};
            hblk_r      <= 1'b1;
            vblk_r      <= 1'b1;
            hsyn_r      <= 1'b1;
            vsyn_r      <= 1'b1;
            frame_stb_r <= 1'b0;
            vbl_stb_r   <= 1'b0;
        end else begin
            frame_stb_r <= 1'b0;
            vbl_stb_r   <= 1'b0;
            if (PCLK_EN) begin
                if (line_end_s) begin
                    hcnt_r <= {CW{1'b0}};
                    vcnt_r <= frame_end_s ? {CW{1'b0}} : vcnt_r + 1'b1;
                end else begin
                    hcnt_r <= hcnt_r + 1'b1;
                end
                if (frame_end_s) begin
                    cfg_r       <= '{mode: hmode_e'(MODE), hoffs: HOFFS, voffs: VOFFS};
                    frame_stb_r <= 1'b1;
                end
                rgb_r     <= rgb_s;
                hblk_r    <= hblk_s;
                vblk_r    <= vblk_s;
                hsyn_r    <= hsyn_s;
                vsyn_r    <= vsyn_s;
                vbl_stb_r <= vblk_s && !vblk_r;
            end
        end
    end

    assign HPOS      = hcnt_r - CW'(HPOS_OFS);
    assign VPOS      = vcnt_r[CW-1] ? (vcnt_r - CW'(VTOTAL)) : vcnt_r;
    assign oRGB      = rgb_r;
    assign HBLK      = hblk_r;
    assign VBLK      = vblk_r;
    assign HSYN      = hsyn_r;
    assign VSYN      = vsyn_r;
    assign FRAME_STB = frame_stb_r;
    assign VBL_STB   = vbl_stb_r;

endmodule

// File: tb/tb_hvgen_param.sv
// Directed bench: default-timing instance plus short-frame and narrow-line
// instances so frame-boundary behaviour fits a modest cycle budget.
module tb_hvgen_param;

    logic        clk = 1'b0;
    logic        reset, pclk_en, mode;
    logic [3:0]  hoffs, voffs;
    logic [3:0]  voffs_w = 4'd0;
    logic [11:0] irgb;

    logic [8:0]  a_hpos, a_vpos, h_hpos, h_vpos, v_hpos, v_vpos, w_hpos, w_vpos;
    logic [11:0] a_rgb, h_rgb, v_rgb, w_rgb;
    logic a_hblk, a_vblk, a_hsyn, a_vsyn, a_fstb, a_vstb;
    logic h_hblk, h_vblk, h_hsyn, h_vsyn, h_fstb, h_vstb;
    logic v_hblk, v_vblk, v_hsyn, v_vsyn, v_fstb, v_vstb;
    logic w_hblk, w_vblk, w_hsyn, w_vsyn, w_fstb, w_vstb;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int v_frames = 0;
    int v_vbls = 0;

    always #5 clk = ~clk;

    hvgen_param dut_a (
        .CLK(clk), .RESET(reset), .PCLK_EN(pclk_en), .MODE(mode), .HOFFS(hoffs), .VOFFS(voffs),
        .iRGB(irgb), .HPOS(a_hpos), .VPOS(a_vpos), .oRGB(a_rgb), .HBLK(a_hblk), .VBLK(a_vblk),
        .HSYN(a_hsyn), .VSYN(a_vsyn), .FRAME_STB(a_fstb), .VBL_STB(a_vstb)
    );

    hvgen_param #(.VTOTAL(4), .VACT(2), .VS_BASE(2), .VS_LEN(1)) dut_h (
        .CLK(clk), .RESET(reset), .PCLK_EN(pclk_en), .MODE(mode), .HOFFS(hoffs), .VOFFS(voffs),
        .iRGB(irgb), .HPOS(h_hpos), .VPOS(h_vpos), .oRGB(h_rgb), .HBLK(h_hblk), .VBLK(h_vblk),
        .HSYN(h_hsyn), .VSYN(h_vsyn), .FRAME_STB(h_fstb), .VBL_STB(h_vstb)
    );

    hvgen_param #(.HTOTAL(40), .HPOS_OFS(2), .HA0_B(4), .HA0_E(36), .HA1_B(6), .HA1_E(34),
                  .HS_BASE(36), .HS_LEN(2)) dut_v (
        .CLK(clk), .RESET(reset), .PCLK_EN(pclk_en), .MODE(mode), .HOFFS(hoffs), .VOFFS(voffs),
        .iRGB(irgb), .HPOS(v_hpos), .VPOS(v_vpos), .oRGB(v_rgb), .HBLK(v_hblk), .VBLK(v_vblk),
        .HSYN(v_hsyn), .VSYN(v_vsyn), .FRAME_STB(v_fstb), .VBL_STB(v_vstb)
    );

    hvgen_param #(.HTOTAL(40), .HPOS_OFS(2), .HA0_B(4), .HA0_E(36), .HA1_B(6), .HA1_E(34),
                  .HS_BASE(36), .HS_LEN(2), .VS_BASE(258)) dut_w (
        .CLK(clk), .RESET(reset), .PCLK_EN(pclk_en), .MODE(mode), .HOFFS(hoffs), .VOFFS(voffs_w),
        .iRGB(irgb), .HPOS(w_hpos), .VPOS(w_vpos), .oRGB(w_rgb), .HBLK(w_hblk), .VBLK(w_vblk),
        .HSYN(w_hsyn), .VSYN(w_vsyn), .FRAME_STB(w_fstb), .VBL_STB(w_vstb)
    );

    // Strobe pulse counters for the narrow-line instance
    always @(negedge clk) begin
        if (v_fstb) v_frames++;
        if (v_vstb) v_vbls++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance so that the counters sit t enables after the last reset
    task automatic goto(input int t);
        tick(t - k);
        k = t;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        k = 0;
    endtask

    task automatic test_reset();
        logic [5:0] flags;
        pclk_en = 1'b1; mode = 1'b0; hoffs = 4'd0; voffs = 4'd0; irgb = 12'hABC;
        do_reset();
        flags = {a_hblk, a_vblk, a_hsyn, a_vsyn, a_fstb, a_vstb};
        checks++; if (a_hpos !== 9'h1F0) begin errors++; $display("FAIL reset_hpos got %h expected %h", a_hpos, 9'h1F0); end
        checks++; if (a_vpos !== 9'h000) begin errors++; $display("FAIL reset_vpos got %h expected %h", a_vpos, 9'h000); end
        checks++; if (flags !== 6'b111100) begin errors++; $display("FAIL reset_flags got %b expected %b", flags, 6'b111100); end
        checks++; if (a_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h expected %h", a_rgb, 12'h000); end
        goto(790);
        checks++; if (a_hpos !== 9'd134) begin errors++; $display("FAIL mid_hpos got %0d expected %0d", a_hpos, 134); end
        checks++; if (a_vpos !== 9'd2) begin errors++; $display("FAIL mid_vpos got %0d expected %0d", a_vpos, 2); end
        checks++; if (a_rgb !== 12'hABC) begin errors++; $display("FAIL mid_rgb got %h expected %h", a_rgb, 12'hABC); end
        pclk_en = 1'b0;
        do_reset();
        pclk_en = 1'b1;
        flags = {a_hblk, a_vblk, a_hsyn, a_vsyn, a_fstb, a_vstb};
        checks++; if (a_hpos !== 9'h1F0) begin errors++; $display("FAIL rst_mid_hpos got %h expected %h", a_hpos, 9'h1F0); end
        checks++; if (a_vpos !== 9'h000) begin errors++; $display("FAIL rst_mid_vpos got %h expected %h", a_vpos, 9'h000); end
        checks++; if (flags !== 6'b111100) begin errors++; $display("FAIL rst_mid_flags got %b expected %b", flags, 6'b111100); end
        checks++; if (a_rgb !== 12'h000) begin errors++; $display("FAIL rst_mid_rgb got %h expected %h", a_rgb, 12'h000); end
    endtask

    task automatic test_pclk_en();
        irgb = 12'hABC;
        do_reset();
        for (int i = 1; i <= 320; i++) begin
            pclk_en = 1'b0;
            tick(2);
            if (i == 31) begin
                checks++; if (a_hpos !== 9'd14) begin errors++; $display("FAIL en_hold_hpos got %0d expected %0d", a_hpos, 14); end
            end
            pclk_en = 1'b1;
            tick(1);
            if (i == 29) begin
                checks++; if (a_hblk !== 1'b1 || a_rgb !== 12'h000) begin errors++; $display("FAIL en_blank28 got %b/%h expected 1/000", a_hblk, a_rgb); end
            end
            if (i == 30) begin
                checks++; if (a_hblk !== 1'b0 || a_rgb !== 12'hABC) begin errors++; $display("FAIL en_active29 got %b/%h expected 0/abc", a_hblk, a_rgb); end
                checks++; if (a_hpos !== 9'd14) begin errors++; $display("FAIL en_hpos30 got %0d expected %0d", a_hpos, 14); end
            end
            if (i == 319) begin
                checks++; if (a_hpos !== 9'd303 || a_vpos !== 9'd0) begin errors++; $display("FAIL en_line_end got %0d/%0d expected 303/0", a_hpos, a_vpos); end
            end
            if (i == 320) begin
                checks++; if (a_hpos !== 9'h1F0 || a_vpos !== 9'd1) begin errors++; $display("FAIL en_line_wrap got %h/%0d expected 1f0/1", a_hpos, a_vpos); end
            end
        end
        pclk_en = 1'b1;
    endtask

    task automatic test_default_hwin();
        do_reset();
        goto(1);
        checks++; if (a_hsyn !== 1'b0) begin errors++; $display("FAIL dflt_hs_h0 got %b expected 0", a_hsyn); end
        goto(8);
        checks++; if (a_hsyn !== 1'b0) begin errors++; $display("FAIL dflt_hs_h7 got %b expected 0", a_hsyn); end
        goto(9);
        checks++; if (a_hsyn !== 1'b1) begin errors++; $display("FAIL dflt_hs_h8 got %b expected 1", a_hsyn); end
        goto(29);
        checks++; if (a_hblk !== 1'b1) begin errors++; $display("FAIL dflt_hb_h28 got %b expected 1", a_hblk); end
        goto(30);
        checks++; if (a_hblk !== 1'b0) begin errors++; $display("FAIL dflt_hb_h29 got %b expected 0", a_hblk); end
        goto(285);
        checks++; if (a_hblk !== 1'b0) begin errors++; $display("FAIL dflt_hb_h284 got %b expected 0", a_hblk); end
        goto(286);
        checks++; if (a_hblk !== 1'b1) begin errors++; $display("FAIL dflt_hb_h285 got %b expected 1", a_hblk); end
        goto(296);
        checks++; if (a_hsyn !== 1'b1 || a_vsyn !== 1'b1) begin errors++; $display("FAIL dflt_hs_h295 got %b/%b expected 1/1", a_hsyn, a_vsyn); end
        goto(297);
        checks++; if (a_hsyn !== 1'b0) begin errors++; $display("FAIL dflt_hs_h296 got %b expected 0", a_hsyn); end
        goto(320);
        checks++; if (a_hsyn !== 1'b0) begin errors++; $display("FAIL dflt_hs_h319 got %b expected 0", a_hsyn); end
    endtask

    task automatic test_mode();
        mode = 1'b0;
        do_reset();
        goto(320);
        mode = 1'b1;
        goto(349);
        checks++; if (h_hblk !== 1'b1) begin errors++; $display("FAIL mode_old_h28 got %b expected 1", h_hblk); end
        goto(350);
        checks++; if (h_hblk !== 1'b0 || h_rgb !== 12'hABC) begin errors++; $display("FAIL mode_old_h29 got %b/%h expected 0/abc", h_hblk, h_rgb); end
        goto(605);
        checks++; if (h_hblk !== 1'b0) begin errors++; $display("FAIL mode_old_h284 got %b expected 0", h_hblk); end
        goto(606);
        checks++; if (h_hblk !== 1'b1) begin errors++; $display("FAIL mode_old_h285 got %b expected 1", h_hblk); end
        goto(1279);
        checks++; if (h_fstb !== 1'b0) begin errors++; $display("FAIL fstb_early got %b expected 0", h_fstb); end
        goto(1280);
        checks++; if (h_fstb !== 1'b1) begin errors++; $display("FAIL fstb_pulse got %b expected 1", h_fstb); end
        goto(1281);
        checks++; if (h_fstb !== 1'b0) begin errors++; $display("FAIL fstb_clear got %b expected 0", h_fstb); end
        goto(1317);
        checks++; if (h_hblk !== 1'b1) begin errors++; $display("FAIL mode_new_h36 got %b expected 1", h_hblk); end
        goto(1318);
        checks++; if (h_hblk !== 1'b0 || h_rgb !== 12'hABC) begin errors++; $display("FAIL mode_new_h37 got %b/%h expected 0/abc", h_hblk, h_rgb); end
        goto(1557);
        checks++; if (h_hblk !== 1'b0) begin errors++; $display("FAIL mode_new_h276 got %b expected 0", h_hblk); end
        goto(1558);
        checks++; if (h_hblk !== 1'b1) begin errors++; $display("FAIL mode_new_h277 got %b expected 1", h_hblk); end
    endtask

    task automatic test_hoffs();
        mode = 1'b0;
        hoffs = 4'd7;
        do_reset();
        goto(9);
        checks++; if (h_hsyn !== 1'b1) begin errors++; $display("FAIL hoffs_unlatched_h8 got %b expected 1", h_hsyn); end
        goto(1281);
        hoffs = 4'b1000;
        goto(1583);
        checks++; if (h_hsyn !== 1'b1) begin errors++; $display("FAIL hoffs_p7_h302 got %b expected 1", h_hsyn); end
        goto(1584);
        checks++; if (h_hsyn !== 1'b0) begin errors++; $display("FAIL hoffs_p7_h303 got %b expected 0", h_hsyn); end
        goto(1600);
        checks++; if (h_hsyn !== 1'b0) begin errors++; $display("FAIL hoffs_p7_h319 got %b expected 0", h_hsyn); end
        goto(1601);
        checks++; if (h_hsyn !== 1'b0) begin errors++; $display("FAIL hoffs_p7_h0 got %b expected 0", h_hsyn); end
        goto(1615);
        checks++; if (h_hsyn !== 1'b0) begin errors++; $display("FAIL hoffs_p7_h14 got %b expected 0", h_hsyn); end
        goto(1616);
        checks++; if (h_hsyn !== 1'b1) begin errors++; $display("FAIL hoffs_p7_h15 got %b expected 1", h_hsyn); end
        goto(2848);
        checks++; if (h_hsyn !== 1'b1) begin errors++; $display("FAIL hoffs_m8_h287 got %b expected 1", h_hsyn); end
        goto(2849);
        checks++; if (h_hsyn !== 1'b0) begin errors++; $display("FAIL hoffs_m8_h288 got %b expected 0", h_hsyn); end
        goto(2880);
        checks++; if (h_hsyn !== 1'b0) begin errors++; $display("FAIL hoffs_m8_h319 got %b expected 0", h_hsyn); end
        goto(2881);
        checks++; if (h_hsyn !== 1'b1) begin errors++; $display("FAIL hoffs_m8_h0 got %b expected 1", h_hsyn); end
        hoffs = 4'd0;
    endtask

    task automatic test_vtiming();
        int f0, b0;
        mode = 1'b0; hoffs = 4'd0; voffs = 4'd7; irgb = 12'hABC;
        do_reset();
        f0 = v_frames;
        b0 = v_vbls;
        goto(8941);
        checks++; if (v_vblk !== 1'b0 || v_rgb !== 12'hABC) begin errors++; $display("FAIL v_line223 got %b/%h expected 0/abc", v_vblk, v_rgb); end
        goto(8960);
        checks++; if (v_vstb !== 1'b0 || v_vblk !== 1'b0) begin errors++; $display("FAIL vbl_before got %b/%b expected 0/0", v_vstb, v_vblk); end
        goto(8961);
        checks++; if (v_vstb !== 1'b1 || v_vblk !== 1'b1) begin errors++; $display("FAIL vbl_rise got %b/%b expected 1/1", v_vstb, v_vblk); end
        goto(8962);
        checks++; if (v_vstb !== 1'b0) begin errors++; $display("FAIL vbl_clear got %b expected 0", v_vstb); end
        goto(8981);
        checks++; if (v_hblk !== 1'b0 || v_rgb !== 12'h000) begin errors++; $display("FAIL v_line224_rgb got %b/%h expected 0/000", v_hblk, v_rgb); end
        goto(9321);
        checks++; if (v_vsyn !== 1'b1) begin errors++; $display("FAIL vs_l233 got %b expected 1", v_vsyn); end
        goto(9361);
        checks++; if (v_vsyn !== 1'b0) begin errors++; $display("FAIL vs_l234 got %b expected 0", v_vsyn); end
        goto(9520);
        checks++; if (v_vsyn !== 1'b0) begin errors++; $display("FAIL vs_l237 got %b expected 0", v_vsyn); end
        goto(9521);
        checks++; if (v_vsyn !== 1'b1) begin errors++; $display("FAIL vs_l238 got %b expected 1", v_vsyn); end
        goto(10200);
        checks++; if (v_vpos !== 9'd255) begin errors++; $display("FAIL vpos_255 got %h expected %h", v_vpos, 9'd255); end
        goto(10240);
        checks++; if (v_vpos !== 9'h1FC) begin errors++; $display("FAIL vpos_256 got %h expected %h", v_vpos, 9'h1FC); end
        goto(10281);
        checks++; if (w_vsyn !== 1'b1) begin errors++; $display("FAIL vsw_l257 got %b expected 1", w_vsyn); end
        goto(10321);
        checks++; if (w_vsyn !== 1'b0) begin errors++; $display("FAIL vsw_l258 got %b expected 0", w_vsyn); end
        goto(10360);
        checks++; if (v_vpos !== 9'h1FF) begin errors++; $display("FAIL vpos_259 got %h expected %h", v_vpos, 9'h1FF); end
        goto(10361);
        checks++; if (w_vsyn !== 1'b0) begin errors++; $display("FAIL vsw_l259 got %b expected 0", w_vsyn); end
        goto(10400);
        checks++; if (v_vpos !== 9'd0 || v_hpos !== 9'h1FE) begin errors++; $display("FAIL v_wrap_pos got %h/%h expected 000/1fe", v_vpos, v_hpos); end
        goto(10401);
        checks++; if (w_vsyn !== 1'b0) begin errors++; $display("FAIL vsw_l0 got %b expected 0", w_vsyn); end
        checks++; if (v_frames - f0 !== 1 || v_vbls - b0 !== 1) begin errors++; $display("FAIL strobe_count1 got %0d/%0d expected 1/1", v_frames - f0, v_vbls - b0); end
        goto(10441);
        checks++; if (w_vsyn !== 1'b0) begin errors++; $display("FAIL vsw_l1 got %b expected 0", w_vsyn); end
        goto(10481);
        checks++; if (w_vsyn !== 1'b1) begin errors++; $display("FAIL vsw_l2 got %b expected 1", w_vsyn); end
        goto(20001);
        checks++; if (v_vsyn !== 1'b1) begin errors++; $display("FAIL vofs_l240 got %b expected 1", v_vsyn); end
        goto(20041);
        checks++; if (v_vsyn !== 1'b0) begin errors++; $display("FAIL vofs_l241 got %b expected 0", v_vsyn); end
        goto(20200);
        checks++; if (v_vsyn !== 1'b0) begin errors++; $display("FAIL vofs_l244 got %b expected 0", v_vsyn); end
        goto(20201);
        checks++; if (v_vsyn !== 1'b1) begin errors++; $display("FAIL vofs_l245 got %b expected 1", v_vsyn); end
        checks++; if (v_frames - f0 !== 1 || v_vbls - b0 !== 2) begin errors++; $display("FAIL strobe_count2 got %0d/%0d expected 1/2", v_frames - f0, v_vbls - b0); end
    endtask

    initial begin
        reset = 1'b1; pclk_en = 1'b1; mode = 1'b0; hoffs = 4'd0; voffs = 4'd0; irgb = 12'hABC;
        test_reset();
        test_pclk_en();
        test_default_hwin();
        test_mode();
        test_hoffs();
        test_vtiming();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
